// File: rtl/trap_sequencer_if.sv
// Decode/pipeline <-> trap_sequencer signal bundle; master is the pipeline side, slave is the sequencer.
// Carries the decode trap flags in and the fetch/ID control and latched trap state out.
interface trap_sequencer_if;
  logic        i_ID_Valid;
  logic [31:0] i_ID_PC;
  logic [31:0] i_ID_InstructionWord;
  logic        i_EnvCall;
  logic        i_EnvBreak;
  logic        i_IllegalInstruction;
  logic        i_TrapReturn;
  logic        i_PipelineEmpty;

  logic        o_Stall;
  logic        o_KillID;
  logic        o_Flush;
  logic        o_Redirect;
  logic [31:0] o_RedirectPC;
  logic        o_InTrap;
  logic [3:0]  o_TrapCause;
  logic [31:0] o_TrapPC;
  logic [31:0] o_TrapValue;
  logic        o_DrainTimeout;
  logic        o_Halted;

  modport master (
    output i_ID_Valid, i_ID_PC, i_ID_InstructionWord, i_EnvCall, i_EnvBreak,
           i_IllegalInstruction, i_TrapReturn, i_PipelineEmpty,
    input  o_Stall, o_KillID, o_Flush, o_Redirect, o_RedirectPC, o_InTrap,
           o_TrapCause, o_TrapPC, o_TrapValue, o_DrainTimeout, o_Halted
  );

  modport slave (
    input  i_ID_Valid, i_ID_PC, i_ID_InstructionWord, i_EnvCall, i_EnvBreak,
           i_IllegalInstruction, i_TrapReturn, i_PipelineEmpty,
    output o_Stall, o_KillID, o_Flush, o_Redirect, o_RedirectPC, o_InTrap,
           o_TrapCause, o_TrapPC, o_TrapValue, o_DrainTimeout, o_Halted
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap sequencer: stall/kill the trapping ID instruction (same cycle), drain EX/MEM/WB, 1-cycle redirect to TRAP_VECTOR, 1-cycle redirect to saved PC+4 on MRET.
// No backpressure input; drain is bounded by DRAIN_TIMEOUT. Define TRAP_DOUBLE_FAULT_EN to make a trap inside the handler halt instead of nesting.
module trap_sequencer #(
  parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
  parameter int unsigned DRAIN_TIMEOUT = 15
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  trap_sequencer_if.slave bus
);

  localparam int unsigned   CW       = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DRAIN_TIMEOUT);

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_REDIRECT = 3'd2,
    S_HANDLER  = 3'd3,
    S_RETURN   = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cause_q, cause_d;
  logic [31:0]   tpc_q, tpc_d;
  logic [31:0]   tval_q, tval_d;
  logic          dto_q, dto_d;

  logic          trap_detect;
  logic [3:0]    new_cause;
  logic [31:0]   new_value;

  logic          stall, kill, flush, redir, intrap, halted;
  logic [31:0]   redir_pc;

  assign trap_detect = bus.i_ID_Valid &
                       (bus.i_IllegalInstruction | bus.i_EnvBreak | bus.i_EnvCall);

  // Illegal outranks EBREAK outranks ECALL when decode raises several flags.
  assign new_cause = bus.i_IllegalInstruction ? CAUSE_ILLEGAL :
                     bus.i_EnvBreak           ? CAUSE_EBREAK  : CAUSE_ECALL;
  assign new_value = bus.i_IllegalInstruction ? bus.i_ID_InstructionWord : 32'd0;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
      tpc_q   <= '0;
      tval_q  <= '0;
      dto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      tpc_q   <= tpc_d;
      tval_q  <= tval_d;
      dto_q   <= dto_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    tpc_d    = tpc_q;
    tval_d   = tval_q;
    dto_d    = dto_q;
    stall    = 1'b0;
    kill     = 1'b0;
    flush    = 1'b0;
    redir    = 1'b0;
    redir_pc = 32'd0;
    intrap   = 1'b0;
    halted   = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = trap_detect;
        kill  = trap_detect;
        if (trap_detect) begin
          cause_d = new_cause;
          tpc_d   = bus.i_ID_PC;
          tval_d  = new_value;
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        stall = 1'b1;
        kill  = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (bus.i_PipelineEmpty) begin
          state_d = S_REDIRECT;
        end else if (cnt_q >= CNT_LAST) begin
          dto_d   = 1'b1;
          state_d = S_REDIRECT;
        end
      end

      S_REDIRECT: begin
        redir    = 1'b1;
        redir_pc = TRAP_VECTOR;
        flush    = 1'b1;
        state_d  = S_HANDLER;
      end

      S_HANDLER: begin
        intrap = 1'b1;
        if (trap_detect) begin
          stall = 1'b1;
          kill  = 1'b1;
`ifdef TRAP_DOUBLE_FAULT_EN
          state_d = S_HALT;
`else
          cause_d = new_cause;
          tpc_d   = bus.i_ID_PC;
          tval_d  = new_value;
          cnt_d   = '0;
          state_d = S_DRAIN;
`endif
        end else if (bus.i_TrapReturn) begin
          state_d = S_RETURN;
        end
      end

      S_RETURN: begin
        redir    = 1'b1;
        redir_pc = tpc_q + 32'd4;
        flush    = 1'b1;
        state_d  = S_IDLE;
      end

`ifdef TRAP_DOUBLE_FAULT_EN
      S_HALT: begin
        halted = 1'b1;
        stall  = 1'b1;
        kill   = 1'b1;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset masks the input-driven IDLE stall so every output drops while reset is held.
  assign bus.o_Stall        = stall & ~i_Reset;
  assign bus.o_KillID       = kill & ~i_Reset;
  assign bus.o_Flush        = flush;
  assign bus.o_Redirect     = redir;
  assign bus.o_RedirectPC   = redir_pc;
  assign bus.o_InTrap       = intrap;
  assign bus.o_TrapCause    = cause_q;
  assign bus.o_TrapPC       = tpc_q;
  assign bus.o_TrapValue    = tval_q;
  assign bus.o_DrainTimeout = dto_q;
  assign bus.o_Halted       = halted;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: each trap scenario is expanded into its expected per-cycle timeline,
// checked every cycle at the falling edge, plus literal pins on key values.
module tb_trap_sequencer;

  localparam int DT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_sequencer_if bus();

  trap_sequencer #(
    .TRAP_VECTOR  (32'h0000_0100),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Architectural trap state the DUT must be holding.
  logic [3:0]  m_cause;
  logic [31:0] m_tpc, m_tval;
  logic        m_dto;

  // Expected control outputs for the current cycle.
  logic        e_stall, e_kill, e_flush, e_redir, e_intrap, e_halted;
  logic [31:0] e_rpc;
  logic        chk_en = 1'b0;

  // Snapshot of DUT outputs taken just after the compare edge.
  logic        s_stall, s_redir, s_halted;
  logic [31:0] s_rpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chkb("stall",    bus.o_Stall,        e_stall);
      chkb("kill",     bus.o_KillID,       e_kill);
      chkb("flush",    bus.o_Flush,        e_flush);
      chkb("redirect", bus.o_Redirect,     e_redir);
      chk ("redir_pc", bus.o_RedirectPC,   e_rpc);
      chkb("in_trap",  bus.o_InTrap,       e_intrap);
      chkb("halted",   bus.o_Halted,       e_halted);
      chk ("cause",    32'(bus.o_TrapCause), 32'(m_cause));
      chk ("trap_pc",  bus.o_TrapPC,       m_tpc);
      chk ("trap_val", bus.o_TrapValue,    m_tval);
      chkb("drain_to", bus.o_DrainTimeout, m_dto);
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] word,
                       input logic ecl, input logic brk, input logic ill,
                       input logic tret, input logic empty);
    bus.i_ID_Valid           = v;
    bus.i_ID_PC              = pc;
    bus.i_ID_InstructionWord = word;
    bus.i_EnvCall            = ecl;
    bus.i_EnvBreak           = brk;
    bus.i_IllegalInstruction = ill;
    bus.i_TrapReturn         = tret;
    bus.i_PipelineEmpty      = empty;
  endtask

  task automatic expect_ctl(input logic st, input logic kl, input logic fl, input logic rd,
                            input logic [31:0] rpc, input logic it, input logic hl);
    e_stall  = st;
    e_kill   = kl;
    e_flush  = fl;
    e_redir  = rd;
    e_rpc    = rpc;
    e_intrap = it;
    e_halted = hl;
  endtask

  // Inputs/expectations are set at posedge+1; compare fires at negedge; returns at next posedge+1.
  task automatic step();
    @(negedge clk);
    #1;
    s_stall  = bus.o_Stall;
    s_redir  = bus.o_Redirect;
    s_rpc    = bus.o_RedirectPC;
    s_halted = bus.o_Halted;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic handler_cycle();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
  endtask

  // Full trap entry: detect cycle, drain until empty_at (or DT), vector redirect, one handler cycle.
  task automatic trap_seq(input logic [31:0] pc, input logic [31:0] word,
                          input logic ecl, input logic brk, input logic ill,
                          input int empty_at, input logic in_handler,
                          output int drain_n, output logic [31:0] vec_pc);
    logic [3:0]  c;
    logic [31:0] v;
    logic        em;
    c = ill ? 4'd2 : (brk ? 4'd3 : 4'd11);
    v = ill ? word : 32'd0;
    drive(1'b1, pc, word, ecl, brk, ill, 1'b0, 1'b0);
    expect_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, in_handler, 1'b0);
    step();
    m_cause = c;
    m_tpc   = pc;
    m_tval  = v;
    drain_n = 0;
    for (int k = 1; k <= 40; k++) begin
      em = (k >= empty_at);
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, em);
      expect_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();
      if (s_stall) drain_n++;
      if (em) break;
      if (k == DT) begin
        m_dto = 1'b1;
        break;
      end
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_ctl(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    step();
    vec_pc = s_rpc;
    handler_cycle();
  endtask

  task automatic trap_ret(output logic [31:0] ret_pc);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_ctl(1'b0, 1'b0, 1'b1, 1'b1, m_tpc + 32'd4, 1'b0, 1'b0);
    step();
    ret_pc = s_rpc;
    idle(1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    m_cause = '0;
    m_tpc   = '0;
    m_tval  = '0;
    m_dto   = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] vpc, rpc;

    rst = 1'b1;
    m_cause = '0;
    m_tpc   = '0;
    m_tval  = '0;
    m_dto   = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    idle(2);

    // ECALL at 0x40, pipeline empty on the third drain cycle.
    trap_seq(32'h0000_0040, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 3, 1'b0, n, vpc);
    chk("ecall_drain_cycles", 32'(n), 32'd3);
    chk("ecall_vector", vpc, 32'h0000_0100);
    chk("ecall_cause_lit", 32'(bus.o_TrapCause), 32'd11);
    chk("ecall_pc_lit", bus.o_TrapPC, 32'h0000_0040);
    chk("ecall_val_lit", bus.o_TrapValue, 32'd0);
    trap_ret(rpc);
    chk("ecall_return_pc", rpc, 32'h0000_0044);

    // Illegal word with ECALL also raised: illegal wins; immediate empty gives a 1-cycle drain.
    trap_seq(32'h0000_0040, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1, 1'b0, n, vpc);
    chk("illegal_drain_cycles", 32'(n), 32'd1);
    chk("illegal_cause_lit", 32'(bus.o_TrapCause), 32'd2);
    chk("illegal_val_lit", bus.o_TrapValue, 32'hFFFF_FFFF);
    handler_cycle();
    trap_ret(rpc);
    chk("illegal_return_pc", rpc, 32'h0000_0044);

    // Pipeline never drains: forced redirect after DT cycles, sticky timeout flag.
    trap_seq(32'h0000_0200, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 99, 1'b0, n, vpc);
    chk("timeout_drain_cycles", 32'(n), 32'd15);
    chkb("timeout_flag_lit", bus.o_DrainTimeout, 1'b1);

    // EBREAK while the handler runs.
`ifdef TRAP_DOUBLE_FAULT_EN
    drive(1'b1, 32'h0000_0300, 32'h0010_0073, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, (k == 1), 1'b1);
      expect_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      step();
    end
    chkb("df_halted_lit", s_halted, 1'b1);
    chk("df_cause_lit", 32'(bus.o_TrapCause), 32'd11);
    reset_pulse();
    idle(1);
`else
    trap_seq(32'h0000_0300, 32'h0010_0073, 1'b0, 1'b1, 1'b0, 2, 1'b1, n, vpc);
    chk("nested_drain_cycles", 32'(n), 32'd2);
    chk("nested_cause_lit", 32'(bus.o_TrapCause), 32'd3);
    trap_ret(rpc);
    chk("nested_return_pc", rpc, 32'h0000_0304);
    chkb("timeout_still_set", bus.o_DrainTimeout, 1'b1);
`endif

    // PC+4 wraps at the top of the address space.
    trap_seq(32'hFFFF_FFFC, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1, 1'b0, n, vpc);
    trap_ret(rpc);
    chk("wrap_return_pc", rpc, 32'h0000_0000);

    // Reset in the middle of a drain; a later MRET in IDLE must not redirect.
    drive(1'b1, 32'h0000_0500, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    m_cause = 4'd11;
    m_tpc   = 32'h0000_0500;
    m_tval  = 32'd0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      step();
    end
    reset_pulse();
    chkb("reset_stall_lit", s_stall, 1'b0);
    chkb("reset_timeout_cleared", bus.o_DrainTimeout, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    idle(2);
    chkb("no_redirect_after_reset", s_redir, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
